// File: rtl/com_pkg.sv
// rtl/com_pkg.sv - shared types and helpers for the chunked branch comparator
package com_pkg;

  typedef enum logic [2:0] {
    OP_EQ  = 3'b000,
    OP_NE  = 3'b001,
    OP_LT  = 3'b100,
    OP_GE  = 3'b101,
    OP_LTU = 3'b110,
    OP_GEU = 3'b111
  } com_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } com_state_e;

  function automatic logic com_is_signed(logic [2:0] op);
    return (op == OP_LT) || (op == OP_GE);
  endfunction

  // Codes 010/011 are reserved and always resolve to 0.
  function automatic logic com_result(logic [2:0] op, logic eq, logic lt);
    case (op)
      OP_EQ:          return eq;
      OP_NE:          return !eq;
      OP_LT, OP_LTU:  return lt;
      OP_GE, OP_GEU:  return !lt;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/com_chunk.sv
// rtl/com_chunk.sv - unsigned equal/less-than compare of one CHUNK-bit slice
module com_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             eq,
  output logic             lt
);

  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/com_seq.sv
// rtl/com_seq.sv - multi-cycle MSB-first chunked branch comparator
module com_seq
  import com_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             res
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW     = NCHUNK * CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NCHUNK - 1);

  com_state_e       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [PW-1:0]    lhs_q, lhs_d, rhs_q, rhs_d;
  logic [PW-1:0]    lhs_ext, rhs_ext;
  logic [IW-1:0]    idx_q, idx_d;
  logic             eq_q, eq_d, lt_q, lt_d;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             chunk_eq, chunk_lt;
  logic             accept, diff_now, last_chunk;

  // Pad to PW bits; signed ops flip the top bit so an unsigned compare orders them.
  always_comb begin
    lhs_ext = '0;
    rhs_ext = '0;
    lhs_ext[WIDTH-1:0] = lhs;
    rhs_ext[WIDTH-1:0] = rhs;
    if (com_is_signed(op)) begin
      for (int i = WIDTH; i < PW; i++) begin
        lhs_ext[i] = lhs[WIDTH-1];
        rhs_ext[i] = rhs[WIDTH-1];
      end
      lhs_ext[PW-1] = ~lhs_ext[PW-1];
      rhs_ext[PW-1] = ~rhs_ext[PW-1];
    end
  end

  assign a_chunk = lhs_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk = rhs_q[idx_q*CHUNK +: CHUNK];

  com_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a  (a_chunk),
    .b  (b_chunk),
    .eq (chunk_eq),
    .lt (chunk_lt)
  );

  assign in_ready   = !reset && !flush &&
                      ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept     = in_valid && in_ready;
  assign diff_now   = eq_q && !chunk_eq;
  assign last_chunk = (idx_q == '0);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    lhs_d   = lhs_q;
    rhs_d   = rhs_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    case (state_q)
      IDLE: ;
      CMP: begin
        // Once a difference is latched the accumulators stay frozen.
        if (diff_now) begin
          eq_d = 1'b0;
          lt_d = chunk_lt;
        end
        if (last_chunk || (EARLY_EXIT && diff_now)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A request taken in DONE chains straight into CMP with no bubble.
    if (accept) begin
      state_d = CMP;
      op_d    = op;
      lhs_d   = lhs_ext;
      rhs_d   = rhs_ext;
      idx_d   = IDX_TOP;
      eq_d    = 1'b1;
      lt_d    = 1'b0;
    end
    if (flush) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      lhs_q   <= '0;
      rhs_q   <= '0;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lhs_q   <= lhs_d;
      rhs_q   <= rhs_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign res       = (state_q == DONE) && com_result(op_q, eq_q, lt_q);

  a_no_valid_in_idle: assert property (@(posedge clk) disable iff (reset)
    (state_q == IDLE) |-> !out_valid);

  a_res_stable: assert property (@(posedge clk) disable iff (reset || flush)
    (out_valid && !out_ready) |=> (out_valid && $stable(res)));

endmodule

// File: tb/tb_com_seq.sv
// tb/tb_com_seq.sv - scoreboard bench for com_seq across three parameter sets
module tb_com_seq;
  import com_pkg::*;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic [2:0]  op;
  logic [31:0] lhs, rhs;
  logic        iv[N], ir[N], ov[N], ordy[N], res[N];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bit exp_res_q[N][$];
  int exp_lat_q[N][$];
  int acc_q[N][$];
  logic prev_v[N], prev_r[N], prev_res[N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dut0: 32/8 early exit, dut1: 32/8 constant latency, dut2: 32/5 padded
  com_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(iv[0]), .in_ready(ir[0]),
    .op(op), .lhs(lhs), .rhs(rhs), .out_valid(ov[0]), .out_ready(ordy[0]), .res(res[0]));
  com_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(iv[1]), .in_ready(ir[1]),
    .op(op), .lhs(lhs), .rhs(rhs), .out_valid(ov[1]), .out_ready(ordy[1]), .res(res[1]));
  com_seq #(.WIDTH(32), .CHUNK(5), .EARLY_EXIT(1'b1)) u_dut2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(iv[2]), .in_ready(ir[2]),
    .op(op), .lhs(lhs), .rhs(rhs), .out_valid(ov[2]), .out_ready(ordy[2]), .res(res[2]));

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: latency is counted from the accept edge up to the first out_valid.
  always @(negedge clk) begin
    for (int d = 0; d < N; d++) begin
      if (reset || flush) acc_q[d].delete();
      else if (iv[d] && ir[d]) acc_q[d].push_back(cyc);
      if (ov[d] && !prev_v[d]) begin
        if (exp_res_q[d].size() == 0 || acc_q[d].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output dut%0d res=%0b expected=none", d, res[d]);
        end else begin
          bit er;
          int el, a;
          er = exp_res_q[d].pop_front();
          el = exp_lat_q[d].pop_front();
          a  = acc_q[d].pop_front();
          check($sformatf("res_dut%0d", d), 32'(res[d]), 32'(er));
          check($sformatf("latency_dut%0d", d), 32'(cyc - a), 32'(el));
        end
      end else if (ov[d] && prev_v[d] && !prev_r[d]) begin
        check($sformatf("res_hold_dut%0d", d), 32'(res[d]), 32'(prev_res[d]));
      end
      prev_v[d]   = ov[d];
      prev_r[d]   = ordy[d];
      prev_res[d] = res[d];
    end
  end

  // el < 0 means the request is expected to be aborted with no output.
  task automatic send(int d, logic [2:0] o, logic [31:0] l, logic [31:0] r, bit er, int el);
    int n;
    @(posedge clk);
    #1;
    if (el >= 0) begin
      exp_res_q[d].push_back(er);
      exp_lat_q[d].push_back(el);
    end
    op = o;
    lhs = l;
    rhs = r;
    iv[d] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ir[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ir[d]) check($sformatf("accept_timeout_dut%0d", d), 32'(ir[d]), 32'd1);
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
  endtask

  task automatic drain(int d);
    int n;
    n = 0;
    while (exp_res_q[d].size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_res_q[d].size() != 0) begin
      check($sformatf("drain_timeout_dut%0d", d), 32'(exp_res_q[d].size()), 32'd0);
      exp_res_q[d].delete();
      exp_lat_q[d].delete();
    end
  endtask

  task automatic wait_valid(int d);
    int n;
    n = 0;
    while (!ov[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ov[d]) check($sformatf("valid_timeout_dut%0d", d), 32'(ov[d]), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    op = '0;
    lhs = '0;
    rhs = '0;
    for (int d = 0; d < N; d++) begin
      iv[d] = 1'b0;
      ordy[d] = 1'b1;
      prev_v[d] = 1'b0;
      prev_r[d] = 1'b1;
      prev_res[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("in_ready_in_reset", 32'(ir[0]), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < N; d++) begin
      check($sformatf("reset_out_valid_dut%0d", d), 32'(ov[d]), 32'd0);
      check($sformatf("reset_res_dut%0d", d), 32'(res[d]), 32'd0);
      check($sformatf("reset_in_ready_dut%0d", d), 32'(ir[d]), 32'd1);
    end

    send(0, OP_EQ, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 5);
    drain(0);
    send(0, OP_LTU, 32'h01000000, 32'h02000000, 1'b1, 2);
    drain(0);
    send(1, OP_LTU, 32'h01000000, 32'h02000000, 1'b1, 5);
    drain(1);
    send(1, OP_NE, 32'h12345678, 32'h12345679, 1'b1, 5);
    drain(1);

    send(0, OP_LT, 32'hFFFFFFFF, 32'h00000001, 1'b1, 2);
    drain(0);
    send(0, OP_LTU, 32'hFFFFFFFF, 32'h00000001, 1'b0, 2);
    drain(0);
    send(0, OP_GE, 32'h80000000, 32'h7FFFFFFF, 1'b0, 2);
    drain(0);
    send(2, OP_LT, 32'hFFFFFFFF, 32'h00000001, 1'b1, 2);
    drain(2);

    // Backpressure for three DONE cycles, then a chained request on release.
    ordy[0] = 1'b0;
    send(0, OP_EQ, 32'h0, 32'h0, 1'b1, 5);
    wait_valid(0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_out_valid", 32'(ov[0]), 32'd1);
      check("bp_in_ready", 32'(ir[0]), 32'd0);
      check("bp_res", 32'(res[0]), 32'd1);
    end
    @(posedge clk);
    #1;
    exp_res_q[0].push_back(1'b1);
    exp_lat_q[0].push_back(2);
    op = OP_LTU;
    lhs = 32'h01000000;
    rhs = 32'h02000000;
    iv[0] = 1'b1;
    ordy[0] = 1'b1;
    @(negedge clk);
    check("b2b_in_ready", 32'(ir[0]), 32'd1);
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    drain(0);

    // Flush on the second CMP cycle.
    send(0, OP_EQ, 32'h5, 32'h5, 1'b0, -1);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(ov[0]), 32'd0);
    check("flush_in_ready", 32'(ir[0]), 32'd1);
    repeat (8) @(negedge clk);

    // Flush beats a same-cycle request in IDLE.
    @(posedge clk);
    #1;
    flush = 1'b1;
    iv[0] = 1'b1;
    @(negedge clk);
    check("flush_idle_in_ready", 32'(ir[0]), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    iv[0] = 1'b0;
    repeat (8) @(negedge clk);

    // Reset mid-compare.
    send(0, OP_EQ, 32'h5, 32'h5, 1'b0, -1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_in_ready", 32'(ir[0]), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_mid_out_valid", 32'(ov[0]), 32'd0);
    check("reset_mid_res", 32'(res[0]), 32'd0);
    check("reset_mid_in_ready_after", 32'(ir[0]), 32'd1);
    repeat (8) @(negedge clk);

    // Flush while a result is held in DONE.
    ordy[1] = 1'b0;
    send(1, OP_EQ, 32'h77, 32'h77, 1'b1, 5);
    wait_valid(1);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    ordy[1] = 1'b1;
    @(negedge clk);
    check("flush_done_out_valid", 32'(ov[1]), 32'd0);
    drain(1);

    send(2, OP_GEU, 32'h80000001, 32'h80000001, 1'b1, 8);
    drain(2);
    send(2, 3'b010, 32'hAAAA5555, 32'hAAAA5555, 1'b0, 8);
    drain(2);
    send(1, 3'b011, 32'h00000001, 32'h00000002, 1'b0, 5);
    drain(1);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/com_seq.md
Name: com_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle branch comparator.
- Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first, with optional early exit on the first differing chunk.
- Uses valid/ready handshakes on both sides.
- Sits between the decode/issue stage and branch resolution on wide-datapath or area-constrained configurations.

Parameters:
- WIDTH, 32, operand width in bits (>= 1).
- CHUNK, 8, bits compared per cycle (1..WIDTH).
- EARLY_EXIT, 1, 1 = finish on the first differing chunk; 0 = always run NCHUNK cycles (constant latency).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  abort any in-flight compare.
- in_valid  in  1  request valid.
- in_ready  out  1  request can be accepted this cycle.
- op  in  3  compare op: EQ=000, NE=001, LT=100, GE=101, LTU=110, GEU=111; 010 and 011 are reserved.
- lhs  in  WIDTH  left operand.
- rhs  in  WIDTH  right operand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- res  out  1  compare result; meaningful while out_valid=1.

Behaviour:
- Reset and clock: one clock (clk); reset is synchronous and active-high.
- Reset response: state=IDLE, out_valid=0, res=0, and all internal registers cleared.
  - in_ready=0 in any cycle with reset=1.
  - Reset mid-compare discards the operation with no output.
- Derived constants:
  - NCHUNK = ceil(WIDTH/CHUNK).
  - PW = NCHUNK*CHUNK.
- Operand padding:
  - Operands are extended to PW bits at capture.
  - LT/GE: sign-extend.
  - All other ops: zero-extend.
  - Signed ops: XOR bit PW-1 of both captured operands, then compare unsigned.
- States:
  - IDLE: in_ready=1. On in_valid, capture op/lhs/rhs, set idx=NCHUNK-1, eq_acc=1, lt_acc=0, go to CMP.
  - CMP: each cycle compare chunk idx of lhs against chunk idx of rhs.
    - If eq_acc=1 and the chunks differ: eq_acc<=0, lt_acc<=(lhs_chunk<rhs_chunk).
    - If eq_acc=0, the accumulators are frozen.
    - Leave CMP for DONE when idx==0, or when EARLY_EXIT=1 and a difference is found this cycle; otherwise idx<=idx-1.
  - DONE: out_valid=1 and res is held stable until out_ready.
- Result mapping:
  - EQ = eq_acc; NE = !eq_acc.
  - LT/LTU = lt_acc; GE/GEU = !lt_acc.
  - Reserved ops = 0, with the same timing as a normal op.
- Latency (accept edge to out_valid):
  - EARLY_EXIT=1: k+1 cycles, where k = 1 + number of equal leading chunks (capped at NCHUNK).
  - EARLY_EXIT=0: NCHUNK+1 cycles.
- Back-to-back:
  - in_ready = IDLE | (DONE & out_ready).
  - A new request accepted in DONE goes directly to CMP; there are no idle bubbles.
- Backpressure: out_ready=0 in DONE holds res and out_valid indefinitely; in_ready=0.
- Flush:
  - In CMP or DONE: go to IDLE next cycle and drop out_valid.
  - Flush has priority over a same-cycle input or output handshake; in_ready=0 while flush=1.
- Degenerate widths: CHUNK=WIDTH gives single-cycle CMP. A non-dividing CHUNK (e.g. WIDTH=32, CHUNK=5) gives NCHUNK=7 with padding.
- Width rules: idx is $clog2(NCHUNK) bits, minimum 1. No arithmetic beyond CHUNK-wide unsigned compare.
- Assertions: out_valid must never be set in IDLE; res must be stable while out_valid & !out_ready.

Decomposition:
- Shared package com_pkg:
  - com_op_e enum (the six codes plus reserved handling).
  - com_state_e {IDLE, CMP, DONE}.
  - Helper function com_is_signed(op).
- Sub-module com_chunk (combinational):
  - Inputs: CHUNK-bit a, b.
  - Outputs: eq, lt (unsigned).
  - Instantiated once on the muxed chunk.

Test Plan:
1. WIDTH=32, CHUNK=8, EARLY_EXIT=1, op=EQ, lhs=rhs=0xDEADBEEF, out_ready=1 -> res=1 after 5 cycles (4 CMP cycles).
2. op=LTU, lhs=0x01000000, rhs=0x02000000 -> res=1 after 2 cycles (early exit on chunk 3); repeat with EARLY_EXIT=0 -> same res after 5 cycles.
3. Signed cases:
   - op=LT, lhs=0xFFFFFFFF (-1), rhs=0x00000001 -> res=1.
   - op=LTU with the same operands -> res=0.
   - op=GE, lhs=0x80000000, rhs=0x7FFFFFFF -> res=0.
4. Backpressure and back-to-back:
   - Hold out_ready=0 for 3 cycles in DONE -> res and out_valid stable, in_ready=0.
   - Assert out_ready with in_valid -> second request accepted that cycle; its result appears with no bubble.
5. Flush and reset:
   - Assert flush on the 2nd CMP cycle -> IDLE next cycle, no out_valid, in_ready=1 after.
   - Same for reset -> out_valid=0, res=0.
6. Non-dividing width: WIDTH=32, CHUNK=5, op=GEU, lhs=rhs=0x80000001 -> res=1 after 8 cycles. Reserved op=010 -> res=0 with normal timing.
